dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the Memory pipeline stage (CPU side) and the backing data RAM (memory side).
- Read hits return data combinationally with no stall.
- Read misses and all writes raise `stall` while a req/ack transaction to backing memory completes.

Parameters:
- SETS, 16, number of lines; power of 2, minimum 2; one 32-bit word per line.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cpu_re  input  1  read request.
- cpu_we  input  1  write request; has priority over cpu_re.
- cpu_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  input  DATA_WIDTH  store data.
- cpu_rdata  output  DATA_WIDTH  load data.
- stall  output  1  pipeline must freeze and hold all cpu_* inputs stable.
- flush  input  1  invalidate all lines.
- mem_req  output  1  backing-memory request.
- mem_we  output  1  1 = write transaction, 0 = read transaction.
- mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1.
- mem_ack  input  1  completes the pending transaction.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high. All state changes happen on the rising edge.
- Address split:
  - index = cpu_addr[2+log2(SETS)-1:2]
  - tag = cpu_addr[ADDR_WIDTH-1:2+log2(SETS)]
- Per-line storage: valid bit, tag, data word.
- hit = valid[index] && tag match.
- Reset:
  - All valid bits cleared; state = IDLE.
  - mem_req = 0, mem_we = 0, stall = 0, cpu_rdata = 0.
  - Reset mid-transaction abandons it: mem_req drops the next cycle, and a later mem_ack is ignored.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - cpu_we=1: stall=1 (combinational, same cycle). Next state WRITE, latching addr/wdata.
  - cpu_re=1 (and cpu_we=0), hit: cpu_rdata = line data, stall=0, stay IDLE.
  - cpu_re=1, miss: stall=1 (combinational). Next state FILL.
  - flush=1 with no access: clear all valid bits at the edge; stall=0.
  - flush=1 with an access: stall=1 for this cycle, clear the valid bits; the access is serviced from the next cycle and therefore misses.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = word-aligned latched address; stall=1.
  - On mem_ack: write mem_rdata, tag and valid into the line, and present mem_rdata on cpu_rdata that cycle.
  - stall is deasserted in the ack cycle (combinationally from mem_ack). Next state IDLE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata from the latched values; stall=1.
  - On mem_ack: if the line hits, update its data (valid/tag unchanged). A miss leaves the cache unchanged (no allocate).
  - stall deasserts in the ack cycle. Next state IDLE.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ack cycle.
  - mem_ack is meaningful only while mem_req=1; otherwise it is ignored.
  - mem_ack in the first FILL/WRITE cycle is legal (minimum latency).
  - mem_req is low in IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss and write: 1 + N stall cycles, where N = cycles from mem_req rising to mem_ack inclusive, minus one.
- flush in FILL/WRITE is ignored (not queued).
- cpu_rdata when not reading a hit or completing a fill: holds its last value.
- Aliasing: addresses sharing an index but differing in tag evict each other on fill.

Test Plan:
- Reset, then read 0x0000_0040 with mem_ack returning 0xDEAD_BEEF after 3 cycles -> stall high 4 cycles, cpu_rdata=0xDEAD_BEEF in the ack cycle. A repeat read of 0x40 -> hit, stall=0, same data, mem_req stays 0.
- Write 0x0000_0040 = 0x1234_5678 after the line is filled -> one WRITE transaction with mem_we=1 and mem_wdata=0x1234_5678. A following read of 0x40 hits and returns 0x1234_5678.
- Write to uncached 0x0000_0080 -> memory write occurs. A subsequent read of 0x80 misses (no allocate) and issues a FILL.
- Alias with SETS=16: fill 0x0000_0040, then read 0x0000_0440 (same index 0) -> miss. Re-read 0x40 -> miss again, because 0x40 was evicted.
- flush asserted in IDLE after filling 0x40 -> next read of 0x40 misses. flush held during a FILL -> no effect, and the fill still completes.
- Reset asserted in the second FILL cycle, then mem_ack pulsed -> mem_req=0 the next cycle, ack ignored, all lines invalid, stall=0.

Source files
------------

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits are served combinationally; misses and stores run a req/ack transaction to backing memory.
module dcache_direct #(
  parameter int SETS       = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SETS-1:0]         r_valid;
  logic [TAG_W-1:0]        r_tag  [SETS];
  logic [DATA_WIDTH-1:0]   r_data [SETS];
  logic [ADDR_WIDTH-3:0]   r_addr_word;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [IDX_W-1:0]        w_cpu_idx;
  logic [TAG_W-1:0]        w_cpu_tag;
  logic [IDX_W-1:0]        w_lat_idx;
  logic [TAG_W-1:0]        w_lat_tag;
  logic                    w_cpu_hit;
  logic                    w_lat_hit;
  logic                    w_latch;
  logic                    w_flush_all;
  logic                    w_fill;
  logic                    w_wr_upd;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused_addr_bits;

  assign w_unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign w_cpu_idx = cpu_addr[2 +: IDX_W];
  assign w_cpu_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_lat_idx = r_addr_word[IDX_W-1:0];
  assign w_lat_tag = r_addr_word[ADDR_WIDTH-3 -: TAG_W];

  assign w_cpu_hit = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);

  // The request fields come only from latched registers, so they stay stable until ack.
  assign mem_addr  = {r_addr_word, 2'b00};
  assign mem_wdata = r_wdata;
  assign cpu_rdata = w_rdata;

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    w_latch      = 1'b0;
    w_flush_all  = 1'b0;
    w_fill       = 1'b0;
    w_wr_upd     = 1'b0;
    w_rdata      = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          // Flush wins this cycle; a concurrent access retries next cycle and misses.
          w_flush_all = 1'b1;
          stall       = cpu_we | cpu_re;
        end else if (cpu_we) begin
          stall        = 1'b1;
          w_latch      = 1'b1;
          w_state_next = S_WRITE;
        end else if (cpu_re) begin
          if (w_cpu_hit) begin
            w_rdata = r_data[w_cpu_idx];
          end else begin
            stall        = 1'b1;
            w_latch      = 1'b1;
            w_state_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_req = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          w_fill       = 1'b1;
          w_rdata      = mem_rdata;
          w_state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          w_wr_upd     = w_lat_hit;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_rdata <= w_rdata;
      if (w_flush_all) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_lat_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr_word <= cpu_addr[ADDR_WIDTH-1:2];
      r_wdata     <= cpu_wdata;
    end
  end

  // Tag/data arrays carry no reset; the valid vector alone defines their meaning.
  always_ff @(posedge clk) begin
    if (!reset && w_fill) begin
      r_tag[w_lat_idx]  <= w_lat_tag;
      r_data[w_lat_idx] <= mem_rdata;
    end else if (!reset && w_wr_upd) begin
      r_data[w_lat_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: expected memory transactions and load data are queued
// when an access is driven and compared when the cache issues the request or releases stall.
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        txn_q[$];
  logic [31:0] data_q[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] last_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem_model.exists(k)) return mem_model[k];
    return k ^ 32'h5A5A_0F0F;
  endfunction

  // fmode: 0 = no flush, 1 = flush with the access in its first cycle, 2 = flush held through the memory transaction
  task automatic cpu_access(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_miss, input int lat, input int fmode);
    int          stall_cnt;
    int          req_cnt;
    int          cyc;
    int          exp_stall;
    logic        done;
    logic [31:0] exp_data;
    txn_t        t;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_we    = is_wr;
    cpu_re    = ~is_wr;
    flush     = (fmode == 1);
    exp_data  = 32'h0;
    if (is_wr) begin
      mem_model[{addr[31:2], 2'b00}] = wdata;
      txn_q.push_back('{we: 1'b1, addr: {addr[31:2], 2'b00}, wdata: wdata});
      exp_stall = 1 + lat;
    end else begin
      data_q.push_back(mem_val(addr));
      if (exp_miss) txn_q.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, wdata: 32'h0});
      exp_stall = (fmode == 1 ? 1 : 0) + (exp_miss ? 1 + lat : 0);
    end
    stall_cnt = 0;
    req_cnt   = 0;
    cyc       = 0;
    done      = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (txn_q.size() == 0) begin
            check_val("unexpected_req", 32'(mem_req), 32'h0);
          end else begin
            t = txn_q.pop_front();
            check_val("mem_we", 32'(mem_we), 32'(t.we));
            check_val("mem_addr", mem_addr, t.addr);
            if (t.we) check_val("mem_wdata", mem_wdata, t.wdata);
          end
          if (fmode == 2) flush = 1'b1;
        end
        if (req_cnt == lat + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(addr);
        end
      end
      #1;
      if (stall) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        if (!is_wr) begin
          exp_data = data_q.pop_front();
          check_val("cpu_rdata", cpu_rdata, exp_data);
          last_rdata = exp_data;
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (fmode == 1 || done) flush = 1'b0;
      cyc++;
    end
    if (!done) check_val("stall_timeout", 32'(done), 32'h1);
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    flush  = 1'b0;
    check_val("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    if (!is_wr && !exp_miss) check_val("hit_req_count", 32'(req_cnt), 32'h0);
    $display("[%0t] %s addr=%h data=%h miss=%0d lat=%0d flush_mode=%0d stall_cycles=%0d",
             $time, is_wr ? "WR" : "RD", addr, is_wr ? wdata : exp_data, exp_miss, lat, fmode, stall_cnt);
    @(negedge clk);
    check_val("rdata_hold", cpu_rdata, last_rdata);
    check_val("idle_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    flush     = 1'b0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    last_rdata = 32'h0;
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_stall", 32'(stall), 32'h0);
    check_val("rst_mem_req", 32'(mem_req), 32'h0);
    check_val("rst_mem_we", 32'(mem_we), 32'h0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'h0);
    @(posedge clk);
    #1;

    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 3, 0);         // cold miss, 4 stall cycles
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b0, 0, 0);         // hit
    cpu_access(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 2, 0); // write hit
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b0, 0, 0);         // updated line hits
    cpu_access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1'b0, 0, 0); // write miss, minimum latency
    cpu_access(1'b0, 32'h0000_0080, 32'h0, 1'b1, 1, 0);         // not allocated by write
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 2, 0);         // 0x80 evicted 0x40
    cpu_access(1'b0, 32'h0000_0440, 32'h0, 1'b1, 1, 0);         // alias on index 0
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 0, 0);         // evicted by alias
    cpu_access(1'b0, 32'h0000_003C, 32'h0, 1'b1, 1, 0);         // top index
    cpu_access(1'b0, 32'h0000_003C, 32'h0, 1'b0, 0, 0);

    // flush alone in idle
    flush = 1'b1;
    @(negedge clk);
    check_val("flush_idle_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 1, 0);
    cpu_access(1'b0, 32'h0000_003C, 32'h0, 1'b1, 0, 0);
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 2, 1);         // flush together with access
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b0, 0, 0);
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 1'b1, 2, 2);         // flush during fill is ignored
    cpu_access(1'b0, 32'h0000_0100, 32'h0, 1'b0, 0, 0);
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 0, 0);

    // reset in the second FILL cycle, then a stray ack
    cpu_re   = 1'b1;
    cpu_addr = 32'h0000_0440;
    @(negedge clk);
    check_val("rst_test_idle_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_test_fill1_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_test_fill2_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cpu_re    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check_val("rst_abort_req", 32'(mem_req), 32'h0);
    check_val("rst_abort_stall", 32'(stall), 32'h0);
    check_val("rst_abort_rdata", cpu_rdata, 32'h0);
    @(posedge clk);
    #1;
    mem_ack    = 1'b0;
    last_rdata = 32'h0;
    $display("[%0t] RST abort of fill addr=00000440", $time);
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 1, 0);
    cpu_access(1'b0, 32'h0000_003C, 32'h0, 1'b1, 0, 0);
    cpu_access(1'b0, 32'h0000_0440, 32'h0, 1'b1, 1, 0);

    check_val("txn_q_empty", 32'(txn_q.size()), 32'h0);
    check_val("data_q_empty", 32'(data_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
